// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the fifo_v4 stream FIFO.
package fifo_pkg;

    typedef enum logic {FIFO_REGISTERED, FIFO_FALL_THROUGH} fifo_mode_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_v4_ctrl.sv
// Pointer, fill-level and flag control for fifo_v4; independent of the payload type.
module fifo_v4_ctrl
    import fifo_pkg::*;
#(
    parameter bit FALL_THROUGH = 1'b0,
    parameter int DEPTH = 8,
    localparam int CNT_WIDTH = cnt_width(DEPTH),
    localparam int PTR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_valid,
    input  logic                 rd_ready,
    input  logic [CNT_WIDTH-1:0] alm_full_th,
    input  logic [CNT_WIDTH-1:0] alm_empty_th,
    output logic                 wr_ready,
    output logic                 rd_valid,
    output logic                 push,
    output logic                 bypass,
    output logic [PTR_WIDTH-1:0] wr_ptr,
    output logic [PTR_WIDTH-1:0] rd_ptr,
    output logic [CNT_WIDTH-1:0] usage,
    output logic                 full,
    output logic                 empty,
    output logic                 alm_full,
    output logic                 alm_empty
);

    logic write;
    logic read;
    logic pop;

    assign full      = (usage == CNT_WIDTH'(DEPTH));
    assign empty     = (usage == '0);
    assign alm_full  = (usage >= alm_full_th);
    assign alm_empty = (usage <= alm_empty_th);

    // In fall-through mode an empty FIFO presents the incoming word as its head.
    assign bypass   = FALL_THROUGH && empty;
    assign wr_ready = !full && !flush;
    assign rd_valid = !flush && (bypass ? wr_valid : !empty);

    assign write = wr_valid && wr_ready;
    assign read  = rd_valid && rd_ready;
    // A word that is both accepted and consumed while bypassing is never stored.
    assign push  = write && !(bypass && read);
    assign pop   = read && !bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
            end
            if (push && !pop) begin
                usage <= usage + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                usage <= usage - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_v4.sv
// Valid/ready stream FIFO with programmable almost-full/empty thresholds.
// Define FIFO_V4_WATERMARK_EN to add the hwm_clr_i/hwm_o high-watermark monitor.
module fifo_v4
    import fifo_pkg::*;
#(
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  DATA_WIDTH   = 32,
    parameter int  DEPTH        = 8,
    parameter type dtype        = logic [DATA_WIDTH-1:0],
    localparam int CNT_WIDTH    = cnt_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 testmode_i,
    input  logic [CNT_WIDTH-1:0] alm_full_th_i,
    input  logic [CNT_WIDTH-1:0] alm_empty_th_i,
    input  dtype                 data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output dtype                 data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] usage_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 alm_full_o,
`ifdef FIFO_V4_WATERMARK_EN
    input  logic                 hwm_clr_i,
    output logic [CNT_WIDTH-1:0] hwm_o,
`endif
    output logic                 alm_empty_o
);

    localparam int PTR_WIDTH = ptr_width(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("fifo_v4: DEPTH must be at least 1");
    end

    logic                 push;
    logic                 bypass;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    dtype                 mem [DEPTH];

    // Storage is ungated, so there is no clock gate for test mode to bypass.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    fifo_v4_ctrl #(
        .FALL_THROUGH (FALL_THROUGH),
        .DEPTH        (DEPTH)
    ) u_ctrl (
        .clk          (clk_i),
        .rst          (rst_i),
        .flush        (flush_i),
        .wr_valid     (valid_i),
        .rd_ready     (ready_i),
        .alm_full_th  (alm_full_th_i),
        .alm_empty_th (alm_empty_th_i),
        .wr_ready     (ready_o),
        .rd_valid     (valid_o),
        .push         (push),
        .bypass       (bypass),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .usage        (usage_o),
        .full         (full_o),
        .empty        (empty_o),
        .alm_full     (alm_full_o),
        .alm_empty    (alm_empty_o)
    );

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_comb begin
        data_o = mem[rd_ptr];
        if (bypass) begin
            data_o = data_i;
        end
    end

`ifdef FIFO_V4_WATERMARK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hwm_o <= '0;
        end else if (hwm_clr_i) begin
            hwm_o <= usage_o;
        end else if (usage_o > hwm_o) begin
            hwm_o <= usage_o;
        end
    end
`endif

`ifndef SYNTHESIS
    head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i && !flush_i) |=> (flush_i || $stable(data_o)));
`endif

endmodule

// File: tb/tb_fifo_v4.sv
// Directed and scoreboard bench for fifo_v4 across registered and fall-through builds.
module tb_fifo_v4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // a_*: DEPTH=5 registered, b_*: DEPTH=4 fall-through, c_*: DEPTH=8 registered
    logic       a_flush, a_vi, a_ri, a_ro, a_vo, a_full, a_empty, a_af, a_ae, a_hclr;
    logic [7:0] a_di, a_do;
    logic [2:0] a_use, a_afth, a_aeth, a_hwm;
    logic       b_flush, b_vi, b_ri, b_ro, b_vo, b_full, b_empty, b_af, b_ae, b_hclr;
    logic [7:0] b_di, b_do;
    logic [2:0] b_use, b_afth, b_aeth, b_hwm;
    logic       c_flush, c_vi, c_ri, c_ro, c_vo, c_full, c_empty, c_af, c_ae, c_hclr;
    logic [7:0] c_di, c_do;
    logic [3:0] c_use, c_afth, c_aeth, c_hwm;

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .testmode_i(1'b0),
        .alm_full_th_i(a_afth), .alm_empty_th_i(a_aeth),
        .data_i(a_di), .valid_i(a_vi), .ready_o(a_ro),
        .data_o(a_do), .valid_o(a_vo), .ready_i(a_ri),
        .usage_o(a_use), .full_o(a_full), .empty_o(a_empty), .alm_full_o(a_af),
`ifdef FIFO_V4_WATERMARK_EN
        .hwm_clr_i(a_hclr), .hwm_o(a_hwm),
`endif
        .alm_empty_o(a_ae));

    fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .testmode_i(1'b0),
        .alm_full_th_i(b_afth), .alm_empty_th_i(b_aeth),
        .data_i(b_di), .valid_i(b_vi), .ready_o(b_ro),
        .data_o(b_do), .valid_o(b_vo), .ready_i(b_ri),
        .usage_o(b_use), .full_o(b_full), .empty_o(b_empty), .alm_full_o(b_af),
`ifdef FIFO_V4_WATERMARK_EN
        .hwm_clr_i(b_hclr), .hwm_o(b_hwm),
`endif
        .alm_empty_o(b_ae));

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(c_flush), .testmode_i(1'b0),
        .alm_full_th_i(c_afth), .alm_empty_th_i(c_aeth),
        .data_i(c_di), .valid_i(c_vi), .ready_o(c_ro),
        .data_o(c_do), .valid_o(c_vo), .ready_i(c_ri),
        .usage_o(c_use), .full_o(c_full), .empty_o(c_empty), .alm_full_o(c_af),
`ifdef FIFO_V4_WATERMARK_EN
        .hwm_clr_i(c_hclr), .hwm_o(c_hwm),
`endif
        .alm_empty_o(c_ae));

    typedef struct {
        logic       v, r, fl;
        logic [7:0] d;
        logic       e_rdy, e_vld;
        int         e_use;
        int         e_dout;   // -1: head payload is don't-care
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input int v, r, fl, d, rdy, vld, use_, dout);
        vec_t m;
        m.v = v[0]; m.r = r[0]; m.fl = fl[0]; m.d = 8'(d);
        m.e_rdy = rdy[0]; m.e_vld = vld[0]; m.e_use = use_; m.e_dout = dout;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    logic [7:0] q [$];
    logic       e_vld, e_rdy;

    initial begin
        rst = 1'b1;
        {a_flush, a_vi, a_ri, a_hclr, a_di} = '0;
        {b_flush, b_vi, b_ri, b_hclr, b_di} = '0;
        {c_flush, c_vi, c_ri, c_hclr, c_di} = '0;
        a_afth = 3'd4; a_aeth = 3'd1;
        b_afth = 3'd3; b_aeth = 3'd0;
        c_afth = 4'd0; c_aeth = 4'd2;

        // DEPTH=5: fill past full, mixed read/write with pointer wrap, then flush
        vecs[0]  = mk(1, 0, 0, 'h11, 1, 0, 0, -1);
        vecs[1]  = mk(1, 0, 0, 'h22, 1, 1, 1, 'h11);
        vecs[2]  = mk(1, 0, 0, 'h33, 1, 1, 2, 'h11);
        vecs[3]  = mk(1, 0, 0, 'h44, 1, 1, 3, 'h11);
        vecs[4]  = mk(1, 0, 0, 'h55, 1, 1, 4, 'h11);
        vecs[5]  = mk(1, 0, 0, 'h66, 0, 1, 5, 'h11);
        vecs[6]  = mk(1, 1, 0, 'h66, 0, 1, 5, 'h11);
        vecs[7]  = mk(0, 1, 0, 'h00, 1, 1, 4, 'h22);
        vecs[8]  = mk(0, 1, 0, 'h00, 1, 1, 3, 'h33);
        vecs[9]  = mk(1, 1, 0, 'h77, 1, 1, 2, 'h44);
        vecs[10] = mk(0, 1, 0, 'h00, 1, 1, 2, 'h55);
        vecs[11] = mk(0, 1, 0, 'h00, 1, 1, 1, 'h77);
        vecs[12] = mk(0, 0, 0, 'h00, 1, 0, 0, -1);
        vecs[13] = mk(1, 0, 0, 'h88, 1, 0, 0, -1);
        vecs[14] = mk(1, 0, 0, 'h99, 1, 1, 1, 'h88);
        vecs[15] = mk(1, 1, 1, 'hAA, 0, 0, 2, -1);
        vecs[16] = mk(0, 0, 0, 'h00, 1, 0, 0, -1);

        #2;
        chk("rst usage",   32'(a_use), 0);
        chk("rst empty",   32'(a_empty), 1);
        chk("rst full",    32'(a_full), 0);
        chk("rst valid",   32'(a_vo), 0);
        chk("rst ready",   32'(a_ro), 1);
        chk("rst alm_e",   32'(a_ae), 1);
        chk("rst alm_f",   32'(a_af), 0);
        chk("rst alm_f th0", 32'(c_af), 1);
        chk("rst ft valid", 32'(b_vo), 0);
`ifdef FIFO_V4_WATERMARK_EN
        chk("rst hwm", 32'(c_hwm), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        c_afth = 4'd6;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_vi = vecs[i].v; a_ri = vecs[i].r; a_flush = vecs[i].fl; a_di = vecs[i].d;
            #1;
            chk($sformatf("vec%0d ready", i), 32'(a_ro), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d valid", i), 32'(a_vo), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d usage", i), 32'(a_use), vecs[i].e_use);
            chk($sformatf("vec%0d full", i),  32'(a_full), 32'(vecs[i].e_use == 5));
            chk($sformatf("vec%0d empty", i), 32'(a_empty), 32'(vecs[i].e_use == 0));
            chk($sformatf("vec%0d alm_f", i), 32'(a_af), 32'(vecs[i].e_use >= 4));
            chk($sformatf("vec%0d alm_e", i), 32'(a_ae), 32'(vecs[i].e_use <= 1));
            if (vecs[i].e_dout >= 0)
                chk($sformatf("vec%0d data", i), 32'(a_do), vecs[i].e_dout);
        end

        // Fall-through, DEPTH=4
        @(negedge clk); b_vi = 1; b_ri = 1; b_di = 8'hA5; #1;
        chk("ft pass valid", 32'(b_vo), 1);
        chk("ft pass data",  32'(b_do), 32'hA5);
        chk("ft pass ready", 32'(b_ro), 1);
        @(negedge clk); b_vi = 0; b_ri = 0; #1;
        chk("ft pass usage", 32'(b_use), 0);
        chk("ft pass empty", 32'(b_empty), 1);
        chk("ft idle valid", 32'(b_vo), 0);
        @(negedge clk); b_vi = 1; b_di = 8'h5A; #1;
        chk("ft store valid", 32'(b_vo), 1);
        chk("ft store data",  32'(b_do), 32'h5A);
        @(negedge clk); b_di = 8'hB1; #1;
        chk("ft stored usage", 32'(b_use), 1);
        chk("ft head held",    32'(b_do), 32'h5A);
        @(negedge clk); b_di = 8'hB2; #1;
        chk("ft usage2", 32'(b_use), 2);
        @(negedge clk); b_di = 8'hC3; b_ri = 1; b_flush = 1; #1;
        chk("flush usage3", 32'(b_use), 3);
        chk("flush ready",  32'(b_ro), 0);
        chk("flush valid",  32'(b_vo), 0);
        @(negedge clk); b_flush = 0; b_vi = 0; b_ri = 0; #1;
        chk("post flush usage", 32'(b_use), 0);
        chk("post flush empty", 32'(b_empty), 1);
        @(negedge clk); b_vi = 1; b_ri = 1; b_di = 8'h3C; #1;
        chk("ft after flush data", 32'(b_do), 32'h3C);
        @(negedge clk); b_vi = 0; b_ri = 0; #1;
        chk("ft after flush usage", 32'(b_use), 0);

        // Thresholds and watermark, DEPTH=8
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); c_vi = 1; c_di = 8'(k); #1;
            chk($sformatf("th fill%0d usage", k), 32'(c_use), k);
            chk($sformatf("th fill%0d alm_f", k), 32'(c_af), 32'(k >= 6));
            chk($sformatf("th fill%0d alm_e", k), 32'(c_ae), 32'(k <= 2));
        end
        @(negedge clk); c_vi = 0; #1;
        chk("th usage7", 32'(c_use), 7);
        chk("th alm_f7", 32'(c_af), 1);
        c_afth = 4'd9; #1;
        chk("th9 alm_f", 32'(c_af), 0);
        c_afth = 4'd7; #1;
        chk("th7 alm_f", 32'(c_af), 1);
        c_afth = 4'd8; #1;
        chk("th8 alm_f", 32'(c_af), 0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); c_ri = 1; #1;
            chk($sformatf("drain%0d data", j), 32'(c_do), j);
            chk($sformatf("drain%0d alm_e", j), 32'(c_ae), 32'((7 - j) <= 2));
        end
        @(negedge clk); c_ri = 0; #1;
        chk("drain usage", 32'(c_use), 2);
`ifdef FIFO_V4_WATERMARK_EN
        chk("hwm peak", 32'(c_hwm), 7);
        c_hclr = 1;
        @(negedge clk); c_hclr = 0; #1;
        chk("hwm clr", 32'(c_hwm), 2);
`endif

        // Random traffic against a queue model on DEPTH=5, with a reset mid-stream
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 500) begin
                a_vi = 0; a_ri = 0;
                rst = 1'b1; #1;
                chk("async rst usage", 32'(a_use), 0);
                chk("async rst valid", 32'(a_vo), 0);
                chk("async rst empty", 32'(a_empty), 1);
                q.delete();
                @(negedge clk);
                rst = 1'b0;
            end
            a_vi = 1'($urandom_range(0, 1));
            a_ri = 1'($urandom_range(0, 1));
            a_di = 8'($urandom);
            #1;
            e_vld = (q.size() != 0);
            e_rdy = (q.size() < 5);
            chk("rand usage", 32'(a_use), q.size());
            chk("rand valid", 32'(a_vo), 32'(e_vld));
            chk("rand ready", 32'(a_ro), 32'(e_rdy));
            chk("rand alm_f", 32'(a_af), 32'(q.size() >= 4));
            chk("rand alm_e", 32'(a_ae), 32'(q.size() <= 1));
            if (e_vld) chk("rand data", 32'(a_do), 32'(q[0]));
            if (e_vld && a_ri) void'(q.pop_front());
            if (e_rdy && a_vi) q.push_back(a_di);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
